// File: rtl/control_unit_if.sv
// Control/status bundle between control_unit and the accumulator DataPath.
// The step strobe exists only when STEP_EN is defined.
interface control_unit_if;
  logic [2:0] IR75;
  logic       Aeq0;
  logic       Apos;
  logic       enter;
`ifdef STEP_EN
  logic       step;
`endif
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic       Aload;
  logic       Sub;
  logic [1:0] Asel;
  logic       halt;
  logic [3:0] state;

  modport master (
`ifdef STEP_EN
    input  step,
`endif
    input  IR75, Aeq0, Apos, enter,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halt, state
  );

  modport slave (
`ifdef STEP_EN
    output step,
`endif
    output IR75, Aeq0, Apos, enter,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halt, state
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator DataPath.
// Optional macro STEP_EN: single-step mode, execute states return to START and wait for step.
module control_unit (
  input  logic           clk,
  input  logic           clear,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_START  = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_INREL  = 4'b0011,
    S_LOAD   = 4'b1000,
    S_STORE  = 4'b1001,
    S_ADD    = 4'b1010,
    S_SUB    = 4'b1011,
    S_INPUT  = 4'b1100,
    S_JZ     = 4'b1101,
    S_JPOS   = 4'b1110,
    S_HALT   = 4'b1111
  } state_e;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

`ifdef STEP_EN
  localparam state_e RETURN_STATE = S_START;
`else
  localparam state_e RETURN_STATE = S_FETCH;
`endif

  state_e state_q, state_d;

  logic       irload_c;
  logic       jmpmux_c;
  logic       pcload_c;
  logic       meminst_c;
  logic       memwr_c;
  logic       aload_c;
  logic       sub_c;
  logic [1:0] asel_c;
  logic       halt_c;

  // State register; clear aborts any instruction immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: begin
`ifdef STEP_EN
        state_d = bus.step ? S_FETCH : S_START;
`else
        state_d = S_FETCH;
`endif
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = state_e'({1'b1, bus.IR75});
      S_LOAD,
      S_STORE,
      S_ADD,
      S_SUB,
      S_JZ,
      S_JPOS:   state_d = RETURN_STATE;
      S_INPUT:  state_d = bus.enter ? S_INREL : S_INPUT;
      // Wait for enter release so one press loads A exactly once.
      S_INREL:  state_d = bus.enter ? S_INREL : RETURN_STATE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_START;
    endcase
  end

  // Output decode: Moore except Aload in INPUT and PCload in JZ/JPOS.
  always_comb begin
    irload_c  = 1'b0;
    jmpmux_c  = 1'b0;
    pcload_c  = 1'b0;
    meminst_c = 1'b0;
    memwr_c   = 1'b0;
    aload_c   = 1'b0;
    sub_c     = 1'b0;
    asel_c    = ASEL_ALU;
    halt_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        irload_c = 1'b1;
        pcload_c = 1'b1;
      end
      S_DECODE: meminst_c = 1'b1;
      S_LOAD: begin
        meminst_c = 1'b1;
        asel_c    = ASEL_RAM;
        aload_c   = 1'b1;
      end
      S_STORE: begin
        meminst_c = 1'b1;
        memwr_c   = 1'b1;
      end
      S_ADD: begin
        meminst_c = 1'b1;
        aload_c   = 1'b1;
      end
      S_SUB: begin
        meminst_c = 1'b1;
        aload_c   = 1'b1;
        sub_c     = 1'b1;
      end
      S_INPUT: begin
        asel_c  = ASEL_IN;
        aload_c = bus.enter;
      end
      S_JZ: begin
        jmpmux_c = 1'b1;
        pcload_c = bus.Aeq0;
      end
      S_JPOS: begin
        jmpmux_c = 1'b1;
        pcload_c = bus.Apos;
      end
      S_HALT:  halt_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.IRload  = irload_c;
  assign bus.JMPmux  = jmpmux_c;
  assign bus.PCload  = pcload_c;
  assign bus.Meminst = meminst_c;
  assign bus.MemWr   = memwr_c;
  assign bus.Aload   = aload_c;
  assign bus.Sub     = sub_c;
  assign bus.Asel    = asel_c;
  assign bus.halt    = halt_c;
  assign bus.state   = 4'(state_q);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit (default build; STEP_EN paths included when defined).
module tb_control_unit;

  logic clk = 1'b0;
  logic clear;

  control_unit_if bus ();

  control_unit u_dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ctl = {halt, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel[1:0]}
  localparam logic [9:0] C_ZERO  = 10'b0_0_0_0_0_0_0_0_00;
  localparam logic [9:0] C_FETCH = 10'b0_1_0_1_0_0_0_0_00;
  localparam logic [9:0] C_DEC   = 10'b0_0_0_0_1_0_0_0_00;
  localparam logic [9:0] C_LOAD  = 10'b0_0_0_0_1_0_1_0_10;
  localparam logic [9:0] C_STORE = 10'b0_0_0_0_1_1_0_0_00;
  localparam logic [9:0] C_ADD   = 10'b0_0_0_0_1_0_1_0_00;
  localparam logic [9:0] C_SUB   = 10'b0_0_0_0_1_0_1_1_00;
  localparam logic [9:0] C_INW   = 10'b0_0_0_0_0_0_0_0_01;
  localparam logic [9:0] C_INL   = 10'b0_0_0_0_0_0_1_0_01;
  localparam logic [9:0] C_JMP0  = 10'b0_0_1_0_0_0_0_0_00;
  localparam logic [9:0] C_JMP1  = 10'b0_0_1_1_0_0_0_0_00;
  localparam logic [9:0] C_HALT  = 10'b1_0_0_0_0_0_0_0_00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] xst, input logic [9:0] xctl);
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = {bus.state, bus.halt, bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst,
             bus.MemWr, bus.Aload, bus.Sub, bus.Asel};
    exp_v = {xst, xctl};
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed state=%b ctl=%b expected state=%b ctl=%b",
             tag, obs[13:10], obs[9:0], exp_v[13:10], exp_v[9:0]);
    end
  endtask

  // From FETCH: go through DECODE with op presented only during DECODE.
  task automatic enter_exec(input logic [2:0] op, input logic [3:0] xst,
                            input logic [9:0] xctl, input string tag);
    bus.IR75 = ~op;
    tick;
    chk({tag, "_decode"}, 4'b0010, C_DEC);
    bus.IR75 = op;
    tick;
    bus.IR75 = ~op;
    #1;
    chk(tag, xst, xctl);
  endtask

  task automatic back_to_fetch(input string tag);
    tick;
`ifdef STEP_EN
    chk({tag, "_to_start"}, 4'b0000, C_ZERO);
    repeat (4) begin
      tick;
      chk({tag, "_step_hold"}, 4'b0000, C_ZERO);
    end
    bus.step = 1'b1;
    tick;
    bus.step = 1'b0;
`endif
    chk({tag, "_to_fetch"}, 4'b0001, C_FETCH);
  endtask

  initial begin
    clear     = 1'b0;
    bus.IR75  = 3'b000;
    bus.Aeq0  = 1'b0;
    bus.Apos  = 1'b0;
    bus.enter = 1'b0;
`ifdef STEP_EN
    bus.step  = 1'b0;
`endif

    // Asynchronous reset, then release.
    #1 clear = 1'b1;
    #1;
    chk("reset_async", 4'b0000, C_ZERO);
    tick;
    tick;
    chk("reset_hold", 4'b0000, C_ZERO);
`ifdef STEP_EN
    bus.step = 1'b1;
`endif
    @(negedge clk);
    clear = 1'b0;
    tick;
`ifdef STEP_EN
    bus.step = 1'b0;
`endif
    chk("start_to_fetch", 4'b0001, C_FETCH);

    // ALU and memory instructions.
    enter_exec(3'b010, 4'b1010, C_ADD, "add");
    back_to_fetch("add");
    enter_exec(3'b011, 4'b1011, C_SUB, "sub");
    back_to_fetch("sub");
    enter_exec(3'b000, 4'b1000, C_LOAD, "load");
    back_to_fetch("load");
    enter_exec(3'b001, 4'b1001, C_STORE, "store");
    back_to_fetch("store");

    // INPUT handshake.
    enter_exec(3'b100, 4'b1100, C_INW, "input");
    repeat (3) begin
      tick;
      chk("input_wait", 4'b1100, C_INW);
    end
    bus.enter = 1'b1;
    #1;
    chk("input_load", 4'b1100, C_INL);
    tick;
    chk("inrel_enter", 4'b0011, C_ZERO);
    tick;
    chk("inrel_held", 4'b0011, C_ZERO);
    bus.enter = 1'b0;
    #1;
    chk("inrel_release", 4'b0011, C_ZERO);
    back_to_fetch("inrel");

    // JZ: PCload follows Aeq0 only.
    bus.Aeq0 = 1'b1;
    bus.Apos = 1'b0;
    enter_exec(3'b101, 4'b1101, C_JMP1, "jz_taken");
    bus.Aeq0 = 1'b0;
    #1;
    chk("jz_not_taken", 4'b1101, C_JMP0);
    bus.Apos = 1'b1;
    #1;
    chk("jz_ignores_apos", 4'b1101, C_JMP0);
    back_to_fetch("jz");

    // JPOS: PCload follows Apos only.
    bus.Apos = 1'b1;
    bus.Aeq0 = 1'b0;
    enter_exec(3'b110, 4'b1110, C_JMP1, "jpos_taken");
    bus.Apos = 1'b0;
    #1;
    chk("jpos_not_taken", 4'b1110, C_JMP0);
    bus.Aeq0 = 1'b1;
    #1;
    chk("jpos_ignores_aeq0", 4'b1110, C_JMP0);
    back_to_fetch("jpos");
    bus.Aeq0 = 1'b0;

    // clear during STORE aborts the write at once.
    enter_exec(3'b001, 4'b1001, C_STORE, "store_abort");
    #2 clear = 1'b1;
    #1;
    chk("store_abort_clear", 4'b0000, C_ZERO);
    #1 clear = 1'b0;
`ifdef STEP_EN
    bus.step = 1'b1;
`endif
    tick;
`ifdef STEP_EN
    bus.step = 1'b0;
`endif
    chk("store_abort_restart", 4'b0001, C_FETCH);

    // HALT is sticky regardless of inputs.
    enter_exec(3'b111, 4'b1111, C_HALT, "halt");
    for (int i = 0; i < 10; i++) begin
      bus.enter = ~bus.enter;
      bus.IR75  = 3'(i);
      bus.Aeq0  = ~bus.Aeq0;
`ifdef STEP_EN
      bus.step  = ~bus.step;
`endif
      tick;
      chk("halt_hold", 4'b1111, C_HALT);
    end
    bus.enter = 1'b0;
`ifdef STEP_EN
    bus.step  = 1'b0;
`endif
    #2 clear = 1'b1;
    #1;
    chk("halt_clear", 4'b0000, C_ZERO);
    #1 clear = 1'b0;
`ifdef STEP_EN
    bus.step = 1'b1;
`endif
    tick;
`ifdef STEP_EN
    bus.step = 1'b0;
`endif
    chk("halt_restart", 4'b0001, C_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing FSM for the 8-bit accumulator `DataPath`. It fetches, decodes and executes the eight-instruction set (LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT) by driving every datapath control line, using `IR75`, `Aeq0` and `Apos` as status. It sits beside `DataPath` at the processor top level and is the only source of its control inputs.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising-edge.
- `clear`  in  1  asynchronous reset, active-high.
- `IR75`  in  3  opcode field from the datapath instruction register.
- `Aeq0`  in  1  accumulator == 0.
- `Apos`  in  1  accumulator > 0 (signed, nonzero, bit7 = 0).
- `enter`  in  1  operator input-strobe, synchronous to `clk`.
- `step`  in  1  single-step request; present only with `STEP_EN`.
- `IRload`, `JMPmux`, `PCload`, `Meminst`, `MemWr`, `Aload`, `Sub`  out  1 each  datapath controls.
- `Asel`  out  2  A-mux select: 00 = ALU, 01 = `in`, 10 = RAM, 11 = unused (never driven).
- `halt`  out  1  high while in HALT.
- `state`  out  4  current state code, for debug display.

## Operation
- State codes: START 0000, FETCH 0001, DECODE 0010, INREL 0011, LOAD 1000, STORE 1001, ADD 1010, SUB 1011, INPUT 1100, JZ 1101, JPOS 1110, HALT 1111.
- Outputs are decoded from `state`. They are Moore outputs, except `Aload` in INPUT and `PCload` in JZ/JPOS. Every output not listed for a state is 0.
- START: all zero → FETCH.
- FETCH: `IRload`=1, `PCload`=1, `JMPmux`=0 (PC+1), `Meminst`=0 → DECODE.
- DECODE: `Meminst`=1 (operand address presented to RAM). Next state = {1, `IR75`}.
- LOAD: `Meminst`=1, `Asel`=10, `Aload`=1.
- STORE: `Meminst`=1, `MemWr`=1.
- ADD: `Meminst`=1, `Asel`=00, `Aload`=1, `Sub`=0.
- SUB: as ADD with `Sub`=1.
- INPUT: `Asel`=01, `Aload`=`enter`.
  - `enter`=0: stay in INPUT.
  - `enter`=1: A loads this cycle → INREL.
- INREL: all zero. Stay while `enter`=1; `enter`=0 → exit. This guarantees one load per press.
- JZ: `JMPmux`=1, `PCload`=`Aeq0`.
- JPOS: `JMPmux`=1, `PCload`=`Apos`.
- Exit of LOAD/STORE/ADD/SUB/JZ/JPOS/INREL: → FETCH (→ START under `STEP_EN`).
- HALT: `halt`=1, all controls 0. Stays until `clear`, regardless of inputs.
- `Asel`=11 never produced; unreachable state codes (0100–0111) → START next edge, outputs 0.

## Timing
- Reset: `clear`=1 forces `state`=0000 immediately (asynchronous). All outputs 0, `halt`=0.
- First edge after `clear` falls: START → FETCH.
- Instruction latency: 3 cycles (FETCH, DECODE, execute). INPUT takes 3 + wait cycles + INREL cycles (≥1).
- `IR75` is sampled only on the DECODE→execute edge. Changes at other times are ignored.
- Mealy outputs (`Aload` in INPUT, `PCload` in JZ/JPOS) follow their input in the same cycle. The datapath registers them on the next rising edge.
- `clear` mid-instruction: abort with no partial write. `MemWr` and `Aload` drop with the state.

## Configuration
- `STEP_EN` defined:
  - `step` port exists.
  - Every execute state (and INREL) returns to START instead of FETCH.
  - START advances to FETCH only when `step`=1; otherwise it holds with all outputs 0.
  - Instruction latency becomes 4 cycles + step wait.
- `STEP_EN` undefined:
  - No `step` port.
  - START is left unconditionally after one cycle.
  - Execute states return directly to FETCH.

## Test plan
- Reset: `clear`=1 → `state`=0000, all outputs 0. Release, 1 edge → `state`=0001 with `IRload`=1, `PCload`=1, `JMPmux`=0. Next edge → 0010 with `Meminst`=1.
- ALU ops, each followed by `state`=0001:
  - `IR75`=010 at DECODE → 1010, `Meminst`=1, `Asel`=00, `Aload`=1, `Sub`=0.
  - `IR75`=011 → 1011, `Sub`=1.
  - `IR75`=000 → 1000, `Asel`=10.
  - `IR75`=001 → 1001, `MemWr`=1, `Aload`=0.
- INPUT handshake: `IR75`=100, `enter`=0 for 3 cycles → stays 1100, `Aload`=0. Then `enter`=1 → `Aload`=1, `Asel`=01, next 0011. `enter` held 2 cycles → stays 0011, `Aload`=0. `enter`=0 → 0001.
- Jumps:
  - JZ with `Aeq0`=1 → `JMPmux`=1, `PCload`=1.
  - JZ with `Aeq0`=0 → `PCload`=0.
  - JPOS with `Apos`=1 → `PCload`=1; with `Apos`=0 → `PCload`=0.
- Halt/reset: `IR75`=111 → 1111, `halt`=1. Holds 10 cycles with `enter` and `IR75` toggling. `clear` pulse mid-cycle → 0000 immediately, `halt`=0.
- `STEP_EN` build: after ADD → 0000. `step`=0 for 4 cycles holds 0000. `step`=1 → 0001.
